// File: rtl/bram_pkg.sv
// Shared constants and helpers for the parametrised true-dual-port block RAM.
package bram_pkg;

  // Per-port write modes: what stage 1 shows on a cycle that writes.
  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Number of byte lanes in a word.
  function automatic int unsigned nbytes(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/bram_port_out.sv
// One port's output path: write-mode mux, synchronous set/reset and optional output register.
module bram_port_out
  import bram_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        WRITE_MODE = WM_WRITE_FIRST,
  parameter int unsigned        OUT_REG    = 0,
  parameter logic [DATA_W-1:0]  SRVAL      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we_any,
  input  logic              ssr,
  input  logic [DATA_W-1:0] rd_old,
  input  logic [DATA_W-1:0] rd_new,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s1_next;

  // Stage-1 next value: hold unless enabled, then SSR, plain read or mode-selected write view.
  always_comb begin
    s1_next = s1;
    if (en) begin
      if (ssr) begin
        s1_next = SRVAL;
      end else if (!we_any) begin
        s1_next = rd_old;
      end else if (WRITE_MODE == WM_WRITE_FIRST) begin
        s1_next = rd_new;
      end else if (WRITE_MODE == WM_READ_FIRST) begin
        s1_next = rd_old;
      end
    end
  end

  // Stage-1 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= SRVAL;
    end else begin
      s1 <= s1_next;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              en_q;
    logic [DATA_W-1:0] s2;

    // Stage 2 follows stage 1 only on the cycle after an enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q <= 1'b0;
        s2   <= SRVAL;
      end else begin
        en_q <= en;
        if (en_q) begin
          s2 <= s1;
        end
      end
    end

    assign dout = s2;
  end else begin : g_direct
    assign dout = s1;
  end

endmodule

// File: rtl/bram_tdp_param.sv
// Parametrised single-clock true-dual-port block RAM with byte enables and collision flag.
module bram_tdp_param
  import bram_pkg::*;
#(
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        ADDR_W       = 9,
  parameter int unsigned        BYTE_W       = 8,
  parameter int unsigned        WRITE_MODE_A = WM_WRITE_FIRST,
  parameter int unsigned        WRITE_MODE_B = WM_WRITE_FIRST,
  parameter int unsigned        OUT_REG      = 0,
  parameter logic [DATA_W-1:0]  SRVAL_A      = '0,
  parameter logic [DATA_W-1:0]  SRVAL_B      = '0,
  localparam int unsigned       NB           = nbytes(DATA_W, BYTE_W)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              ENA,
  input  logic [NB-1:0]     WEA,
  input  logic              SSRA,
  input  logic [ADDR_W-1:0] ADDRA,
  input  logic [DATA_W-1:0] DIA,
  output logic [DATA_W-1:0] DOA,
  input  logic              ENB,
  input  logic [NB-1:0]     WEB,
  input  logic              SSRB,
  input  logic [ADDR_W-1:0] ADDRB,
  input  logic [DATA_W-1:0] DIB,
  output logic [DATA_W-1:0] DOB,
  output logic              COLLISION
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  // Storage is never cleared; it powers up as zero in two-state simulation.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] post_a;
  logic [DATA_W-1:0] post_b;
  logic [NB-1:0]     be_a;
  logic [NB-1:0]     be_b;
  logic              same_addr;
  logic              collision_c;

  // Overlay the enabled bytes of din onto base.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] din,
                                              input logic [NB-1:0]     be);
    logic [DATA_W-1:0] w;
    w = base;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) begin
        w[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
      end
    end
    return w;
  endfunction

  assign be_a      = ENA ? WEA : '0;
  assign be_b      = ENB ? WEB : '0;
  assign same_addr = (ADDRA == ADDRB);
  assign rd_a      = mem[ADDRA];
  assign rd_b      = mem[ADDRB];

  // Post-write word at each address: B bytes first, A bytes on top so A wins shared lanes.
  assign post_a = merge(merge(rd_a, DIB, same_addr ? be_b : '0), DIA, be_a);
  assign post_b = merge(merge(rd_b, DIB, be_b), DIA, same_addr ? be_a : '0);

  assign collision_c = ENA & ENB & same_addr & ((|WEA) | (|WEB));

  // Memory write; reset only blocks the write, contents persist.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
    end else begin
      if (|be_b) begin
        mem[ADDRB] <= post_b;
      end
      if (|be_a) begin
        mem[ADDRA] <= post_a;
      end
    end
  end

  // Collision flag, one cycle after the conflicting access.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      COLLISION <= 1'b0;
    end else begin
      COLLISION <= collision_c;
    end
  end

  bram_port_out #(
    .DATA_W     (DATA_W),
    .WRITE_MODE (WRITE_MODE_A),
    .OUT_REG    (OUT_REG),
    .SRVAL      (SRVAL_A)
  ) u_out_a (
    .clk    (CLK),
    .rst_n  (reset_n),
    .en     (ENA),
    .we_any (|be_a),
    .ssr    (SSRA),
    .rd_old (rd_a),
    .rd_new (post_a),
    .dout   (DOA)
  );

  bram_port_out #(
    .DATA_W     (DATA_W),
    .WRITE_MODE (WRITE_MODE_B),
    .OUT_REG    (OUT_REG),
    .SRVAL      (SRVAL_B)
  ) u_out_b (
    .clk    (CLK),
    .rst_n  (reset_n),
    .en     (ENB),
    .we_any (|be_b),
    .ssr    (SSRB),
    .rd_old (rd_b),
    .rd_new (post_b),
    .dout   (DOB)
  );

endmodule

// File: tb/tb_bram_tdp_param.sv
// Directed bench for bram_tdp_param: three configurations sharing one clock and reset.
module tb_bram_tdp_param;
  import bram_pkg::*;

  localparam logic [71:0] SRVAL_A2 = 72'hFF_0000_0000_0000_5A5A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // u0: 32x512, A write-first, B read-first
  logic        ena0, enb0, ssra0, ssrb0, coll0;
  logic [3:0]  wea0, web0;
  logic [8:0]  addra0, addrb0;
  logic [31:0] dia0, dib0, doa0, dob0;
  // u1: 32x512, both no-change
  logic        ena1, enb1, ssra1, ssrb1, coll1;
  logic [3:0]  wea1, web1;
  logic [8:0]  addra1, addrb1;
  logic [31:0] dia1, dib1, doa1, dob1;
  // u2: 72x1024, output register
  logic        ena2, enb2, ssra2, ssrb2, coll2;
  logic [8:0]  wea2, web2;
  logic [9:0]  addra2, addrb2;
  logic [71:0] dia2, dib2, doa2, dob2;
  logic [71:0] d2 [4];

  bram_tdp_param #(
    .WRITE_MODE_A(WM_WRITE_FIRST), .WRITE_MODE_B(WM_READ_FIRST), .SRVAL_A(32'hDEAD_BEEF)
  ) u0 (
    .CLK(clk), .reset_n(rst_n),
    .ENA(ena0), .WEA(wea0), .SSRA(ssra0), .ADDRA(addra0), .DIA(dia0), .DOA(doa0),
    .ENB(enb0), .WEB(web0), .SSRB(ssrb0), .ADDRB(addrb0), .DIB(dib0), .DOB(dob0),
    .COLLISION(coll0)
  );

  bram_tdp_param #(
    .WRITE_MODE_A(WM_NO_CHANGE), .WRITE_MODE_B(WM_NO_CHANGE)
  ) u1 (
    .CLK(clk), .reset_n(rst_n),
    .ENA(ena1), .WEA(wea1), .SSRA(ssra1), .ADDRA(addra1), .DIA(dia1), .DOA(doa1),
    .ENB(enb1), .WEB(web1), .SSRB(ssrb1), .ADDRB(addrb1), .DIB(dib1), .DOB(dob1),
    .COLLISION(coll1)
  );

  bram_tdp_param #(
    .DATA_W(72), .ADDR_W(10), .OUT_REG(1), .SRVAL_A(SRVAL_A2)
  ) u2 (
    .CLK(clk), .reset_n(rst_n),
    .ENA(ena2), .WEA(wea2), .SSRA(ssra2), .ADDRA(addra2), .DIA(dia2), .DOA(doa2),
    .ENB(enb2), .WEB(web2), .SSRB(ssrb2), .ADDRB(addrb2), .DIB(dib2), .DOB(dob2),
    .COLLISION(coll2)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a0(input logic en, input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
    ena0 = en; wea0 = we; addra0 = a; dia0 = d;
  endtask
  task automatic set_b0(input logic en, input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
    enb0 = en; web0 = we; addrb0 = a; dib0 = d;
  endtask
  task automatic set_a1(input logic en, input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
    ena1 = en; wea1 = we; addra1 = a; dia1 = d;
  endtask
  task automatic set_b1(input logic en, input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
    enb1 = en; web1 = we; addrb1 = a; dib1 = d;
  endtask
  task automatic set_a2(input logic en, input logic [8:0] we, input logic [9:0] a, input logic [71:0] d);
    ena2 = en; wea2 = we; addra2 = a; dia2 = d;
  endtask

  initial begin
    set_a0(0, '0, '0, '0); set_b0(0, '0, '0, '0); ssra0 = 0; ssrb0 = 0;
    set_a1(0, '0, '0, '0); set_b1(0, '0, '0, '0); ssra1 = 0; ssrb1 = 0;
    set_a2(0, '0, '0, '0); ssra2 = 0; ssrb2 = 0;
    enb2 = 0; web2 = '0; addrb2 = '0; dib2 = '0;
    for (int i = 0; i < 4; i++) d2[i] = {8'(8'hC0 + i), 64'h0123_4567_89AB_CDE0 + 64'(i)};

    // reset state
    #12;
    check_eq("rst_doa0", 72'(doa0), 72'hDEAD_BEEF);
    check_eq("rst_dob0", 72'(dob0), 72'h0);
    check_eq("rst_coll0", 72'(coll0), 72'h0);
    check_eq("rst_doa2", doa2, SRVAL_A2);
    check_eq("rst_doa1", 72'(doa1), 72'h0);
    #10 rst_n = 1'b1;
    tick();

    set_a0(1, 4'h0, 9'd0, '0); tick();
    check_eq("rd_addr0", 72'(doa0), 72'h0);

    // byte-enable write
    set_a0(1, 4'hF, 9'd5, 32'h1122_3344); tick();
    check_eq("wr_full_wf", 72'(doa0), 72'h1122_3344);
    set_a0(1, 4'b0010, 9'd5, 32'hAABB_CCDD); tick();
    check_eq("wr_byte_wf", 72'(doa0), 72'h1122_CC44);
    set_a0(0, '0, 9'd0, '0); set_b0(1, 4'h0, 9'd5, '0); tick();
    check_eq("rd_byte_b", 72'(dob0), 72'h1122_CC44);
    set_b0(0, 4'h0, 9'd6, '0); tick();
    check_eq("en0_hold", 72'(dob0), 72'h1122_CC44);

    // write modes
    set_a0(1, 4'hF, 9'd7, 32'd1); tick();
    set_a0(1, 4'hF, 9'd7, 32'd2); tick();
    check_eq("wf_doa", 72'(doa0), 72'd2);
    set_a0(0, '0, 9'd0, '0); set_b0(1, 4'hF, 9'd7, 32'd3); tick();
    check_eq("rf_dob", 72'(dob0), 72'd2);
    set_b0(0, '0, 9'd0, '0); set_a0(1, 4'h0, 9'd7, '0); tick();
    check_eq("rf_stored", 72'(doa0), 72'd3);

    // both writing the same address
    set_a0(1, 4'hC, 9'd9, 32'hAAAA_0000); set_b0(1, 4'hF, 9'd9, 32'h0000_BBBB); tick();
    check_eq("coll_ww_flag", 72'(coll0), 72'h1);
    check_eq("coll_ww_doa", 72'(doa0), 72'hAAAA_BBBB);
    check_eq("coll_ww_dob", 72'(dob0), 72'h0);
    set_a0(0, '0, 9'd0, '0); set_b0(0, '0, 9'd0, '0); tick();
    check_eq("coll_ww_pulse", 72'(coll0), 72'h0);
    set_a0(1, 4'h0, 9'd9, '0); tick();
    check_eq("coll_ww_stored", 72'(doa0), 72'hAAAA_BBBB);

    // A reads while B writes
    set_a0(1, 4'h0, 9'd9, '0); set_b0(1, 4'hF, 9'd9, 32'h1234_5678); tick();
    check_eq("coll_rw_doa", 72'(doa0), 72'hAAAA_BBBB);
    check_eq("coll_rw_flag", 72'(coll0), 72'h1);
    set_a0(0, '0, 9'd0, '0); set_b0(0, '0, 9'd0, '0); tick();
    check_eq("coll_rw_pulse", 72'(coll0), 72'h0);
    set_a0(1, 4'h0, 9'd9, '0); set_b0(1, 4'h0, 9'd9, '0); tick();
    check_eq("rr_no_coll", 72'(coll0), 72'h0);
    check_eq("coll_rw_stored", 72'(dob0), 72'h1234_5678);
    set_a0(1, 4'hF, 9'd10, 32'h0A0A_0A0A); set_b0(1, 4'hF, 9'd9, 32'h0B0B_0B0B); tick();
    check_eq("diff_addr_no_coll", 72'(coll0), 72'h0);
    check_eq("rf_dob_pre", 72'(dob0), 72'h1234_5678);
    set_b0(0, '0, 9'd0, '0);

    // SSR with a write still executing
    ssra0 = 1; set_a0(1, 4'hF, 9'd20, 32'h55); tick();
    check_eq("ssr_doa", 72'(doa0), 72'hDEAD_BEEF);
    ssra0 = 0; set_a0(1, 4'h0, 9'd20, '0); tick();
    check_eq("ssr_write_done", 72'(doa0), 72'h55);

    // top address
    set_a0(1, 4'hF, 9'd511, 32'hCAFE_0001); tick();
    set_a0(1, 4'h0, 9'd0, '0); tick();
    check_eq("addr0_untouched", 72'(doa0), 72'h0);
    set_a0(1, 4'h0, 9'd511, '0); tick();
    check_eq("addr_top", 72'(doa0), 72'hCAFE_0001);
    set_a0(0, '0, 9'd0, '0);

    // no-change mode
    set_a1(1, 4'hF, 9'd7, 32'd1); tick();
    check_eq("nc_hold_a", 72'(doa1), 72'h0);
    set_a1(1, 4'h0, 9'd7, '0); tick();
    check_eq("nc_rd_a", 72'(doa1), 72'd1);
    set_a1(1, 4'hF, 9'd7, 32'd2); tick();
    check_eq("nc_hold_a2", 72'(doa1), 72'd1);
    set_a1(0, '0, 9'd0, '0); set_b1(1, 4'h0, 9'd7, '0); tick();
    check_eq("nc_rd_b", 72'(dob1), 72'd2);
    set_b1(1, 4'hF, 9'd7, 32'd5); tick();
    check_eq("nc_hold_b", 72'(dob1), 72'd2);
    set_b1(1, 4'h0, 9'd7, '0); tick();
    check_eq("nc_rd_b2", 72'(dob1), 72'd5);
    set_b1(0, '0, 9'd0, '0);

    // output register: fill, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set_a2(1, 9'h1FF, 10'(i), d2[i]); tick();
    end
    set_a2(0, '0, '0, '0); tick();
    for (int i = 0; i < 5; i++) begin
      set_a2(i < 4, '0, 10'(i), '0); tick();
      if (i == 0) check_eq("oreg_lat0", doa2, d2[3]);
      else        check_eq($sformatf("oreg_rd%0d", i - 1), doa2, d2[i - 1]);
    end

    // SSR mid-stream lands one cycle later than stage 1
    set_a2(1, '0, 10'd0, '0); tick();
    ssra2 = 1; set_a2(1, '0, 10'd1, '0); tick();
    check_eq("oreg_pre_ssr", doa2, d2[0]);
    ssra2 = 0; set_a2(1, '0, 10'd2, '0); tick();
    check_eq("oreg_ssr", doa2, SRVAL_A2);
    set_a2(0, '0, 10'd0, '0); tick();
    check_eq("oreg_post_ssr", doa2, d2[2]);

    // async reset mid write burst
    set_a0(1, 4'hF, 9'd32, 32'h0BAD_0000); tick();
    set_a0(1, 4'hF, 9'd33, 32'h1111_0000); tick();
    set_a0(1, 4'hF, 9'd32, 32'h9999_9999);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_doa0", 72'(doa0), 72'hDEAD_BEEF);
    check_eq("arst_dob0", 72'(dob0), 72'h0);
    check_eq("arst_doa2", doa2, SRVAL_A2);
    tick();
    #3 rst_n = 1'b1;
    set_a0(1, 4'h0, 9'd32, '0); tick();
    check_eq("abort_unchanged", 72'(doa0), 72'h0BAD_0000);
    set_a0(1, 4'h0, 9'd33, '0); tick();
    check_eq("burst_kept", 72'(doa0), 72'h1111_0000);
    set_a0(0, '0, 9'd0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
